// File: rtl/sobel_avalon_bridge.sv
// Responder for the Sobel core's memory port: services pixel reads and drains
// buffered edge-pixel writes as Avalon-MM master transactions.
module sobel_avalon_bridge #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_read_en,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_rd_busy,
  output logic [31:0]       core_read_word,
  output logic              core_data_ready,
  input  logic              core_write_en,
  input  logic [ADDR_W-1:0] core_waddr,
  input  logic [31:0]       core_wdata,
  output logic              core_wfull,
  output logic              bridge_idle,
  output logic              err_overflow,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

  state_t            state_reg, state_next;
  logic              pending_reg;
  logic [ADDR_W-1:0] rd_addr_reg;
  logic              data_ready_reg;
  logic [31:0]       read_word_reg;
  logic              wfull_reg;
  logic              overflow_reg;
  logic              idle_reg;
  logic              avm_read_reg, avm_read_next;
  logic              avm_write_reg, avm_write_next;
  logic [ADDR_W-1:0] avm_address_reg, avm_address_next;
  logic [31:0]       avm_writedata_reg, avm_writedata_next;

  logic [ADDR_W-1:0] fifo_addr_mem [FIFO_DEPTH];
  logic [31:0]       fifo_data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic              rd_accept;
  logic              rd_done;
  logic              pop;
  logic              push_ok;
  logic              push_drop;
  logic              fifo_full;
  logic [ADDR_W-1:0] rd_addr_sel;
  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       head_data;

  assign core_rd_busy    = pending_reg | data_ready_reg;
  assign core_read_word  = read_word_reg;
  assign core_data_ready = data_ready_reg;
  assign core_wfull      = wfull_reg;
  assign bridge_idle     = idle_reg;
  assign err_overflow    = overflow_reg;
  assign avm_address     = avm_address_reg;
  assign avm_read        = avm_read_reg;
  assign avm_write       = avm_write_reg;
  assign avm_writedata   = avm_writedata_reg;
  assign avm_byteenable  = 4'hF;

  assign rd_accept = core_read_en & ~core_rd_busy;
  assign fifo_full = (count_reg == FULL_CNT);
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign pop       = (state_reg == WR_REQ) & ~avm_waitrequest;
  assign push_ok   = core_write_en & (~fifo_full | pop);
  assign push_drop = core_write_en & fifo_full & ~pop;
  assign count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop);

  assign rd_addr_sel = rd_accept ? core_addr : rd_addr_reg;
  // An empty FIFO means the head is the entry being pushed this very cycle.
  assign head_addr = (count_reg == '0) ? core_waddr : fifo_addr_mem[rd_ptr_reg];
  assign head_data = (count_reg == '0) ? core_wdata : fifo_data_mem[rd_ptr_reg];

  always_comb begin
    state_next         = state_reg;
    avm_read_next      = avm_read_reg;
    avm_write_next     = avm_write_reg;
    avm_address_next   = avm_address_reg;
    avm_writedata_next = avm_writedata_reg;
    rd_done            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_next == FULL_CNT) begin
          state_next         = WR_REQ;
          avm_write_next     = 1'b1;
          avm_address_next   = head_addr & WORD_MASK;
          avm_writedata_next = head_data;
        end else if (pending_reg | rd_accept) begin
          state_next       = RD_REQ;
          avm_read_next    = 1'b1;
          avm_address_next = rd_addr_sel & WORD_MASK;
        end else if (count_next != '0) begin
          state_next         = WR_REQ;
          avm_write_next     = 1'b1;
          avm_address_next   = head_addr & WORD_MASK;
          avm_writedata_next = head_data;
        end
      end
      RD_REQ: begin
        if (!avm_waitrequest) begin
          state_next    = RD_WAIT;
          avm_read_next = 1'b0;
        end
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          state_next = IDLE;
          rd_done    = 1'b1;
        end
      end
      WR_REQ: begin
        if (!avm_waitrequest) begin
          state_next     = IDLE;
          avm_write_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      pending_reg       <= 1'b0;
      rd_addr_reg       <= '0;
      data_ready_reg    <= 1'b0;
      read_word_reg     <= '0;
      wfull_reg         <= 1'b0;
      overflow_reg      <= 1'b0;
      idle_reg          <= 1'b1;
      avm_read_reg      <= 1'b0;
      avm_write_reg     <= 1'b0;
      avm_address_reg   <= '0;
      avm_writedata_reg <= '0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
    end else begin
      state_reg         <= state_next;
      avm_read_reg      <= avm_read_next;
      avm_write_reg     <= avm_write_next;
      avm_address_reg   <= avm_address_next;
      avm_writedata_reg <= avm_writedata_next;
      data_ready_reg    <= rd_done;
      if (rd_done) begin
        pending_reg   <= 1'b0;
        read_word_reg <= avm_readdata;
      end else if (rd_accept) begin
        pending_reg <= 1'b1;
        rd_addr_reg <= core_addr;
      end
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg    <= count_next;
      wfull_reg    <= (count_next == FULL_CNT);
      overflow_reg <= overflow_reg | push_drop;
      idle_reg     <= (state_reg == IDLE) & ~pending_reg & (count_reg == '0);
    end
  end

  // Storage carries no reset so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_addr_mem[wr_ptr_reg] <= core_waddr;
      fifo_data_mem[wr_ptr_reg] <= core_wdata;
    end
  end

endmodule

// File: tb/tb_sobel_avalon_bridge.sv
// Directed bench for sobel_avalon_bridge: reads, stalls, write drain,
// arbitration, overflow and reset behaviour, all cycle-exact.
module tb_sobel_avalon_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_read_en;
  logic [31:0] core_addr;
  logic        core_rd_busy;
  logic [31:0] core_read_word;
  logic        core_data_ready;
  logic        core_write_en;
  logic [31:0] core_waddr;
  logic [31:0] core_wdata;
  logic        core_wfull;
  logic        bridge_idle;
  logic        err_overflow;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sobel_avalon_bridge #(.FIFO_DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .core_read_en(core_read_en), .core_addr(core_addr),
    .core_rd_busy(core_rd_busy), .core_read_word(core_read_word),
    .core_data_ready(core_data_ready),
    .core_write_en(core_write_en), .core_waddr(core_waddr),
    .core_wdata(core_wdata), .core_wfull(core_wfull),
    .bridge_idle(bridge_idle), .err_overflow(err_overflow),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_avm_read"}, {31'd0, avm_read}, 32'd0);
    chk({tag, "_avm_write"}, {31'd0, avm_write}, 32'd0);
    chk({tag, "_avm_address"}, avm_address, 32'd0);
    chk({tag, "_avm_writedata"}, avm_writedata, 32'd0);
    chk({tag, "_read_word"}, core_read_word, 32'd0);
    chk({tag, "_data_ready"}, {31'd0, core_data_ready}, 32'd0);
    chk({tag, "_rd_busy"}, {31'd0, core_rd_busy}, 32'd0);
    chk({tag, "_wfull"}, {31'd0, core_wfull}, 32'd0);
    chk({tag, "_overflow"}, {31'd0, err_overflow}, 32'd0);
    chk({tag, "_bridge_idle"}, {31'd0, bridge_idle}, 32'd1);
  endtask

  // Waits (bounded) for the next Avalon write, checks it, and lets it complete.
  task automatic drain_expect(input string tag, input logic [31:0] addr, input logic [31:0] data);
    bit found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (avm_write === 1'b1) begin
        chk({tag, "_addr"}, avm_address, addr);
        chk({tag, "_data"}, avm_writedata, data);
        chk({tag, "_no_read"}, {31'd0, avm_read}, 32'd0);
        found = 1'b1;
        tick();
        break;
      end
      tick();
    end
    chk({tag, "_seen"}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    core_read_en = 1'b0;
    core_addr = '0;
    core_write_en = 1'b0;
    core_waddr = '0;
    core_wdata = '0;
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    avm_readdatavalid = 1'b0;
    tick();
    tick();
    chk_reset_outputs("rst0");
    chk("rst0_byteenable", {28'd0, avm_byteenable}, 32'h0000_000F);
    rst = 1'b0;
    tick();

    // Single read, zero wait states
    core_addr = 32'h0000_1003;
    core_read_en = 1'b1;
    tick();
    core_read_en = 1'b0;
    chk("rd1_avm_read", {31'd0, avm_read}, 32'd1);
    chk("rd1_addr", avm_address, 32'h0000_1000);
    chk("rd1_busy", {31'd0, core_rd_busy}, 32'd1);
    tick();
    chk("rd1_read_dropped", {31'd0, avm_read}, 32'd0);
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hA5A5_5A5A;
    tick();
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    chk("rd1_ready", {31'd0, core_data_ready}, 32'd1);
    chk("rd1_word", core_read_word, 32'hA5A5_5A5A);
    chk("rd1_busy_ready", {31'd0, core_rd_busy}, 32'd1);
    tick();
    chk("rd1_ready_pulse", {31'd0, core_data_ready}, 32'd0);
    chk("rd1_busy_low", {31'd0, core_rd_busy}, 32'd0);
    chk("rd1_word_held", core_read_word, 32'hA5A5_5A5A);

    // Read with three waitrequest cycles
    core_addr = 32'h0000_3008;
    core_read_en = 1'b1;
    tick();
    core_read_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("rd2_read_c%0d", i), {31'd0, avm_read}, 32'd1);
      chk($sformatf("rd2_addr_c%0d", i), avm_address, 32'h0000_3008);
      avm_waitrequest = (i < 4);
      tick();
    end
    chk("rd2_read_dropped", {31'd0, avm_read}, 32'd0);
    chk("rd2_no_early_ready", {31'd0, core_data_ready}, 32'd0);
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h1234_5678;
    tick();
    avm_readdatavalid = 1'b0;
    chk("rd2_ready", {31'd0, core_data_ready}, 32'd1);
    chk("rd2_word", core_read_word, 32'h1234_5678);
    tick();

    // Three queued writes drain in order
    avm_waitrequest = 1'b1;
    core_write_en = 1'b1;
    core_waddr = 32'h0000_2000;
    core_wdata = 32'h11;
    tick();
    chk("wr3_first_write", {31'd0, avm_write}, 32'd1);
    chk("wr3_first_addr", avm_address, 32'h0000_2000);
    chk("wr3_first_data", avm_writedata, 32'h11);
    core_waddr = 32'h0000_2004;
    core_wdata = 32'h22;
    tick();
    chk("wr3_not_idle", {31'd0, bridge_idle}, 32'd0);
    core_waddr = 32'h0000_2008;
    core_wdata = 32'h33;
    tick();
    core_write_en = 1'b0;
    chk("wr3_not_full", {31'd0, core_wfull}, 32'd0);
    avm_waitrequest = 1'b0;
    drain_expect("wr3_a", 32'h0000_2000, 32'h11);
    drain_expect("wr3_b", 32'h0000_2004, 32'h22);
    drain_expect("wr3_c", 32'h0000_2008, 32'h33);
    tick();
    tick();
    chk("wr3_idle", {31'd0, bridge_idle}, 32'd1);
    chk("wr3_write_low", {31'd0, avm_write}, 32'd0);

    // Pending read beats two queued writes
    avm_waitrequest = 1'b1;
    core_write_en = 1'b1;
    core_waddr = 32'h0000_4000;
    core_wdata = 32'hA1;
    tick();
    core_waddr = 32'h0000_4004;
    core_wdata = 32'hB2;
    tick();
    core_waddr = 32'h0000_4008;
    core_wdata = 32'hC3;
    core_read_en = 1'b1;
    core_addr = 32'h0000_5000;
    tick();
    core_write_en = 1'b0;
    core_read_en = 1'b0;
    chk("arb1_w0_write", {31'd0, avm_write}, 32'd1);
    chk("arb1_w0_addr", avm_address, 32'h0000_4000);
    chk("arb1_busy", {31'd0, core_rd_busy}, 32'd1);
    avm_waitrequest = 1'b0;
    tick();
    chk("arb1_idle_write", {31'd0, avm_write}, 32'd0);
    chk("arb1_idle_read", {31'd0, avm_read}, 32'd0);
    tick();
    chk("arb1_read_first", {31'd0, avm_read}, 32'd1);
    chk("arb1_read_addr", avm_address, 32'h0000_5000);
    chk("arb1_no_write", {31'd0, avm_write}, 32'd0);
    tick();
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hDEAD_BEEF;
    tick();
    avm_readdatavalid = 1'b0;
    chk("arb1_ready", {31'd0, core_data_ready}, 32'd1);
    chk("arb1_word", core_read_word, 32'hDEAD_BEEF);
    drain_expect("arb1_wb", 32'h0000_4004, 32'hB2);
    drain_expect("arb1_wc", 32'h0000_4008, 32'hC3);

    // Full FIFO beats a pending read; push+pop while full succeeds
    avm_waitrequest = 1'b1;
    core_write_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      core_waddr = 32'h0000_6000 + 32'(4 * i);
      core_wdata = 32'h60 + 32'(i);
      if (i == 3) begin
        core_read_en = 1'b1;
        core_addr = 32'h0000_7000;
      end
      tick();
    end
    core_read_en = 1'b0;
    chk("arb2_full", {31'd0, core_wfull}, 32'd1);
    chk("arb2_w0_addr", avm_address, 32'h0000_6000);
    core_waddr = 32'h0000_6010;
    core_wdata = 32'h64;
    avm_waitrequest = 1'b0;
    tick();
    core_write_en = 1'b0;
    chk("arb2_still_full", {31'd0, core_wfull}, 32'd1);
    chk("arb2_no_overflow", {31'd0, err_overflow}, 32'd0);
    chk("arb2_idle_read", {31'd0, avm_read}, 32'd0);
    tick();
    chk("arb2_write_first", {31'd0, avm_write}, 32'd1);
    chk("arb2_w1_addr", avm_address, 32'h0000_6004);
    chk("arb2_w1_data", avm_writedata, 32'h61);
    chk("arb2_no_read", {31'd0, avm_read}, 32'd0);
    tick();
    tick();
    chk("arb2_read_next", {31'd0, avm_read}, 32'd1);
    chk("arb2_read_addr", avm_address, 32'h0000_7000);
    tick();
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h0BAD_F00D;
    tick();
    avm_readdatavalid = 1'b0;
    chk("arb2_ready", {31'd0, core_data_ready}, 32'd1);
    chk("arb2_word", core_read_word, 32'h0BAD_F00D);
    drain_expect("arb2_w2", 32'h0000_6008, 32'h62);
    drain_expect("arb2_w3", 32'h0000_600C, 32'h63);
    drain_expect("arb2_w4", 32'h0000_6010, 32'h64);

    // Overflow on a fifth push while stalled, then reset clears it
    avm_waitrequest = 1'b1;
    core_write_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      core_waddr = 32'h0000_8000 + 32'(4 * i);
      core_wdata = 32'h80 + 32'(i);
      if (i == 4) chk("ovf_before", {31'd0, err_overflow}, 32'd0);
      tick();
    end
    core_write_en = 1'b0;
    chk("ovf_set", {31'd0, err_overflow}, 32'd1);
    chk("ovf_full", {31'd0, core_wfull}, 32'd1);
    tick();
    tick();
    chk("ovf_sticky", {31'd0, err_overflow}, 32'd1);
    chk("ovf_stalled_addr", avm_address, 32'h0000_8000);
    rst = 1'b1;
    tick();
    chk_reset_outputs("rst1");
    rst = 1'b0;
    avm_waitrequest = 1'b0;
    tick();
    tick();
    chk("rst1_fifo_cleared", {31'd0, avm_write}, 32'd0);

    // Reset while waiting for read data
    core_addr = 32'h0000_9000;
    core_read_en = 1'b1;
    tick();
    core_read_en = 1'b0;
    chk("rst2_read", {31'd0, avm_read}, 32'd1);
    tick();
    chk("rst2_wait_busy", {31'd0, core_rd_busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_read_low", {31'd0, avm_read}, 32'd0);
    chk("rst2_no_ready", {31'd0, core_data_ready}, 32'd0);
    chk("rst2_busy_low", {31'd0, core_rd_busy}, 32'd0);
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hFFFF_FFFF;
    tick();
    avm_readdatavalid = 1'b0;
    chk("rst2_stray_ready", {31'd0, core_data_ready}, 32'd0);
    chk("rst2_word", core_read_word, 32'd0);
    tick();
    chk("rst2_stray_ready2", {31'd0, core_data_ready}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_avalon_bridge.md
# sobel_avalon_bridge

Bridge between the Sobel core's pixel request port and the system Avalon-MM bus. Answers the core's read requests (`read_enable` plus `pixAddress`) by running Avalon read transactions and returning `read_word` and `data_ready`. Buffers the core's output writes (`write_out_enable`, `sobel_pixel`, write address) in a 4-entry FIFO and drains them as Avalon write transactions. It is the responder end of the core's memory interface and sits between `sobel_edge_detection` and the Avalon interconnect.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: write FIFO entries; must be a power of 2.
- `ADDR_W`, default 32: address width.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: reset, synchronous and active-high.
- `core_read_en` in 1: core read request, sampled when `core_rd_busy`=0.
- `core_addr` in ADDR_W: read byte address, latched on acceptance.
- `core_rd_busy` out 1: a read is pending or in flight; new requests are ignored.
- `core_read_word` out 32: returned pixel word, held until the next read completes.
- `core_data_ready` out 1: one-cycle pulse when `core_read_word` is updated.
- `core_write_en` in 1: push `{core_waddr, core_wdata}` into the write FIFO.
- `core_waddr` in ADDR_W: write byte address.
- `core_wdata` in 32: edge pixel word.
- `core_wfull` out 1: write FIFO full.
- `bridge_idle` out 1: FSM in IDLE, no pending read, FIFO empty.
- `err_overflow` out 1: sticky; a push was attempted while the FIFO was full.
- `avm_address` out ADDR_W: word-aligned address, bits [1:0] forced to 0.
- `avm_read` out 1, `avm_write` out 1, `avm_writedata` out 32, `avm_byteenable` out 4 (constant 4'hF).
- `avm_waitrequest` in 1, `avm_readdata` in 32, `avm_readdatavalid` in 1.

## Operation

- Read acceptance: `core_read_en`=1 with `core_rd_busy`=0 latches `core_addr` and sets the pending-read flag. `core_rd_busy` goes high from the next cycle until the cycle after `core_data_ready`.
- Write push: `core_write_en`=1 with the FIFO not full writes the entry. A push while full is dropped and sets `err_overflow`, which only `rst` clears. A push and a pop in the same cycle while full: the pop frees the slot first, so the push succeeds.
- FSM states:
  - IDLE: if the FIFO is full, go to WR_REQ. Else if a read is pending, go to RD_REQ. Else if the FIFO is non-empty, go to WR_REQ.
  - RD_REQ: `avm_read`=1 and `avm_address` = latched address. Held until `avm_waitrequest`=0, then go to RD_WAIT.
  - RD_WAIT: on `avm_readdatavalid`, register `avm_readdata` into `core_read_word`, pulse `core_data_ready`, clear pending, go to IDLE.
  - WR_REQ: `avm_write`=1 with the FIFO head address and data. Held until `avm_waitrequest`=0, then pop and go to IDLE.
- `avm_address` and `avm_writedata` are stable whenever `avm_read` or `avm_write` is high. `avm_read` and `avm_write` are never high together.
- Only one read is outstanding at a time. Writes drain in FIFO order.
- Reset values: `avm_read`, `avm_write`, `core_data_ready`, `core_rd_busy`, `core_wfull`, `err_overflow` = 0. `avm_address`, `avm_writedata`, `core_read_word` = 0. `bridge_idle` = 1. FIFO pointers = 0, FSM = IDLE.
- Reset mid-transaction: the next edge clears all state and drops `avm_read` / `avm_write` immediately. The pending read is discarded with no `core_data_ready`.

## Timing

- Request accepted at cycle N: `avm_read` high at N+1.
- With `avm_waitrequest`=0 at N+1 and `avm_readdatavalid` at N+2: `core_data_ready` and `core_read_word` are valid at N+3. Minimum read latency is 3 cycles.
- Each waitrequest cycle or readdatavalid delay adds one cycle.
- A write pushed at cycle N into an empty FIFO with the FSM in IDLE and no pending read: `avm_write` high at N+1, popped at the end of the first cycle with waitrequest low.
- Back-to-back writes: one write per 2 cycles (WR_REQ, then IDLE).
- `core_wfull` is registered and reflects the count after the current edge's push/pop.
- `bridge_idle` is registered and updates one cycle after the last state change.

## Test plan

- Single read: accept `core_addr`=0x0000_1003 at N, waitrequest 0, readdatavalid with 0xA5A5_5A5A at N+2. Expect `avm_address`=0x0000_1000 at N+1, `core_data_ready` pulse and `core_read_word`=0xA5A5_5A5A at N+3, `core_rd_busy` low at N+4.
- Waitrequest stall: hold `avm_waitrequest`=1 for 3 cycles during RD_REQ. Expect `avm_read` and address stable for 4 cycles and the data returned 3 cycles later than in the first scenario.
- Write drain: push 3 writes (0x2000/0x11, 0x2004/0x22, 0x2008/0x33) on consecutive cycles. Expect 3 Avalon writes in that order, then `bridge_idle`=1.
- Arbitration: a read pending plus 2 queued writes → read issued first. A read pending with the FIFO full (4 entries) → one write issued first, then the read.
- Overflow: with the FIFO full and the bus stalled, a 5th push is dropped, `err_overflow`=1 and stays 1. Assert `rst` → all outputs return to reset values.
- Reset mid-read: assert `rst` during RD_WAIT. Expect `avm_read`=0, no `core_data_ready`, `core_rd_busy`=0 after the edge.
